// File: rtl/lidar_frame_unpacker_if.sv
// rtl/lidar_frame_unpacker_if.sv - byte-in / point-record-out bundle for lidar_frame_unpacker
interface lidar_frame_unpacker_if #(
    parameter int POINTS = 12
);
    localparam int IW = $clog2(POINTS);

    logic          in_valid;
    logic [7:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_angle;
    logic [15:0]   out_dist;
    logic [7:0]    out_intensity;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic [15:0]   speed;
    logic [15:0]   timestamp;
    logic          busy;
    logic          crc_err;
    logic          overrun;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_angle, out_dist, out_intensity, out_index, out_last,
        input  speed, timestamp, busy, crc_err, overrun
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_angle, out_dist, out_intensity, out_index, out_last,
        output speed, timestamp, busy, crc_err, overrun
    );
endinterface

// File: rtl/lidar_frame_unpacker.sv
// rtl/lidar_frame_unpacker.sv - LD06-style packet framer, sample buffer and interpolated point streamer
// CRC-8 checking of each packet is enabled by defining LIDAR_CRC_CHECK_EN.
module lidar_frame_unpacker #(
    parameter int          POINTS     = 12,
    parameter logic [7:0]  HEADER     = 8'h54,
    parameter logic [7:0]  VERLEN     = 8'h2C,
    parameter int          ANGLE_FULL = 36000
) (
    input  logic clk,
    input  logic rst,
    lidar_frame_unpacker_if.slave bus
);
    localparam int L  = 11 + 3 * POINTS;
    localparam int CW = $clog2(L);
    localparam int IW = $clog2(POINTS);

    localparam logic [CW-1:0] C_SPD0 = CW'(2);
    localparam logic [CW-1:0] C_SPD1 = CW'(3);
    localparam logic [CW-1:0] C_STA0 = CW'(4);
    localparam logic [CW-1:0] C_STA1 = CW'(5);
    localparam logic [CW-1:0] C_SAMP = CW'(6);
    localparam logic [CW-1:0] C_END0 = CW'(6 + 3 * POINTS);
    localparam logic [CW-1:0] C_END1 = CW'(7 + 3 * POINTS);
    localparam logic [CW-1:0] C_TS0  = CW'(8 + 3 * POINTS);
    localparam logic [CW-1:0] C_TS1  = CW'(9 + 3 * POINTS);
    localparam logic [CW-1:0] C_CRC  = CW'(L - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(POINTS - 1);
    localparam logic [15:0]   DIV16  = 16'(POINTS - 1);
    localparam logic [15:0]   AF16   = 16'(ANGLE_FULL);
    localparam logic [17:0]   AF18   = 18'(ANGLE_FULL);

    typedef enum logic [2:0] {HUNT, VER, BODY, CHECK, DIVIDE, EMIT} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] pt_q;
    logic [1:0]    sub_q;
    logic [7:0]    dlo_q, dhi_q;
    logic [15:0]   spd_tmp_q, ts_tmp_q, start_q, end_q;
    logic          crc_bad_q;
    logic [3:0]    div_cnt_q;
    logic [15:0]   quo_q, rem_q, err_q;
    logic          out_valid_q, out_last_q;
    logic [15:0]   out_angle_q, out_dist_q;
    logic [7:0]    out_intensity_q;
    logic [IW-1:0] out_index_q;
    logic [15:0]   speed_q, timestamp_q;
    logic          crc_err_q, overrun_q;
    logic [23:0]   samp_q [POINTS];

    logic          crc_bad_d;
    logic          in_samp, samp_we, step;
    logic [16:0]   rem_sh, err_sum;
    logic [17:0]   ang_sum;
    logic [15:0]   rem_nxt, quo_nxt, err_nxt, ang_nxt, delta_w;
    logic [IW-1:0] nxt_idx;

    always_comb begin
        in_samp = (cnt_q >= C_SAMP) && (cnt_q < C_END0);
        samp_we = (state_q == BODY) && bus.in_valid && in_samp && (sub_q == 2'd2);
        // One restoring-divide step: quotient bits shift in at the bottom of quo_q.
        rem_sh = {rem_q, quo_q[15]};
        if (rem_sh >= {1'b0, DIV16}) begin
            rem_nxt = 16'(rem_sh - {1'b0, DIV16});
            quo_nxt = {quo_q[14:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[15:0];
            quo_nxt = {quo_q[14:0], 1'b0};
        end
        err_sum = {1'b0, err_q} + {1'b0, rem_q};
        step    = (err_sum >= {1'b0, DIV16});
        err_nxt = step ? 16'(err_sum - {1'b0, DIV16}) : err_sum[15:0];
        ang_sum = {2'b00, out_angle_q} + {2'b00, quo_q} + {17'b0, step};
        ang_nxt = (ang_sum >= AF18) ? 16'(ang_sum - AF18) : ang_sum[15:0];
        delta_w = (end_q >= start_q) ? (end_q - start_q) : (end_q + AF16 - start_q);
        nxt_idx = out_index_q + IW'(1);
    end

`ifdef LIDAR_CRC_CHECK_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ({x[6:0], 1'b0} ^ 8'h4D) : {x[6:0], 1'b0};
        return x;
    endfunction

    // A repeated HEADER in VER restarts the running CRC, matching the parser resync.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else if (bus.in_valid) begin
            case (state_q)
                HUNT: if (bus.in_data == HEADER) crc_q <= crc8_byte(8'h00, bus.in_data);
                VER: begin
                    if (bus.in_data == VERLEN)      crc_q <= crc8_byte(crc_q, bus.in_data);
                    else if (bus.in_data == HEADER) crc_q <= crc8_byte(8'h00, bus.in_data);
                end
                BODY: if (cnt_q != C_CRC) crc_q <= crc8_byte(crc_q, bus.in_data);
                default: ;
            endcase
        end
    end

    assign crc_bad_d = (crc_q != bus.in_data);
`else
    assign crc_bad_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (samp_we) samp_q[pt_q] <= {dhi_q, dlo_q, bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= HUNT;
            cnt_q           <= '0;
            pt_q            <= '0;
            sub_q           <= '0;
            dlo_q           <= '0;
            dhi_q           <= '0;
            spd_tmp_q       <= '0;
            ts_tmp_q        <= '0;
            start_q         <= '0;
            end_q           <= '0;
            crc_bad_q       <= 1'b0;
            div_cnt_q       <= '0;
            quo_q           <= '0;
            rem_q           <= '0;
            err_q           <= '0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_angle_q     <= '0;
            out_dist_q      <= '0;
            out_intensity_q <= '0;
            out_index_q     <= '0;
            speed_q         <= '0;
            timestamp_q     <= '0;
            crc_err_q       <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            crc_err_q <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                HUNT: if (bus.in_valid && bus.in_data == HEADER) state_q <= VER;
                VER: begin
                    if (bus.in_valid) begin
                        if (bus.in_data == VERLEN) begin
                            state_q <= BODY;
                            cnt_q   <= C_SPD0;
                            pt_q    <= '0;
                            sub_q   <= '0;
                        end else if (bus.in_data != HEADER) begin
                            state_q <= HUNT;
                        end
                    end
                end
                BODY: begin
                    if (bus.in_valid) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == C_SPD0) spd_tmp_q[7:0]  <= bus.in_data;
                        if (cnt_q == C_SPD1) spd_tmp_q[15:8] <= bus.in_data;
                        if (cnt_q == C_STA0) start_q[7:0]    <= bus.in_data;
                        if (cnt_q == C_STA1) start_q[15:8]   <= bus.in_data;
                        if (cnt_q == C_END0) end_q[7:0]      <= bus.in_data;
                        if (cnt_q == C_END1) end_q[15:8]     <= bus.in_data;
                        if (cnt_q == C_TS0)  ts_tmp_q[7:0]   <= bus.in_data;
                        if (cnt_q == C_TS1)  ts_tmp_q[15:8]  <= bus.in_data;
                        if (in_samp) begin
                            case (sub_q)
                                2'd0: begin dlo_q <= bus.in_data; sub_q <= 2'd1; end
                                2'd1: begin dhi_q <= bus.in_data; sub_q <= 2'd2; end
                                default: begin sub_q <= 2'd0; pt_q <= pt_q + IW'(1); end
                            endcase
                        end
                        if (cnt_q == C_CRC) begin
                            state_q   <= CHECK;
                            crc_bad_q <= crc_bad_d;
                            crc_err_q <= crc_bad_d;
                        end
                    end
                end
                CHECK: begin
                    overrun_q <= bus.in_valid;
                    if (crc_bad_q) begin
                        state_q <= HUNT;
                    end else begin
                        speed_q     <= spd_tmp_q;
                        timestamp_q <= ts_tmp_q;
                        quo_q       <= delta_w;
                        rem_q       <= '0;
                        div_cnt_q   <= '0;
                        state_q     <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    overrun_q <= bus.in_valid;
                    quo_q     <= quo_nxt;
                    rem_q     <= rem_nxt;
                    div_cnt_q <= div_cnt_q + 4'd1;
                    if (div_cnt_q == 4'd15) begin
                        state_q         <= EMIT;
                        out_valid_q     <= 1'b1;
                        out_angle_q     <= start_q;
                        out_dist_q      <= samp_q[0][23:8];
                        out_intensity_q <= samp_q[0][7:0];
                        out_index_q     <= '0;
                        out_last_q      <= 1'b0;
                        err_q           <= '0;
                    end
                end
                EMIT: begin
                    overrun_q <= bus.in_valid;
                    if (out_valid_q && bus.out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            state_q     <= HUNT;
                        end else begin
                            out_index_q     <= nxt_idx;
                            out_angle_q     <= ang_nxt;
                            err_q           <= err_nxt;
                            out_dist_q      <= samp_q[nxt_idx][23:8];
                            out_intensity_q <= samp_q[nxt_idx][7:0];
                            out_last_q      <= (nxt_idx == IDX_LAST);
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_angle     = out_angle_q;
    assign bus.out_dist      = out_dist_q;
    assign bus.out_intensity = out_intensity_q;
    assign bus.out_index     = out_index_q;
    assign bus.out_last      = out_last_q;
    assign bus.speed         = speed_q;
    assign bus.timestamp     = timestamp_q;
    assign bus.busy          = (state_q == DIVIDE) || (state_q == EMIT);
    assign bus.crc_err       = crc_err_q;
    assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_lidar_frame_unpacker.sv
// tb/tb_lidar_frame_unpacker.sv - directed, table-driven bench for lidar_frame_unpacker (POINTS=12 and POINTS=2)
module tb_lidar_frame_unpacker;
`ifdef LIDAR_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lidar_frame_unpacker_if #(.POINTS(12)) bus ();
    lidar_frame_unpacker_if #(.POINTS(2))  bus2 ();

    lidar_frame_unpacker #(.POINTS(12)) dut  (.clk(clk), .rst(rst), .bus(bus));
    lidar_frame_unpacker #(.POINTS(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [15:0] start_a;
        logic [15:0] end_a;
        logic [15:0] spd;
        logic [15:0] ts;
        bit          bad;
        int          a1;
        int          a6;
        int          a11;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] pkt [$];
    int         ang_seen [12];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic logic [15:0] exp_dist(input int p);
        return 16'h4953 + 16'(p * 273);
    endfunction

    function automatic logic [7:0] exp_int(input int p);
        return 8'(8'hC5 + p * 3);
    endfunction

    function automatic int model_angle(input int s, input int e, input int np, input int p);
        int d, a;
        d = (e >= s) ? (e - s) : (e + 36000 - s);
        a = s + (p * d) / (np - 1);
        if (a >= 36000) a -= 36000;
        return a;
    endfunction

    task automatic build_pkt(input int np, input logic [15:0] s, input logic [15:0] e,
                             input logic [15:0] spd, input logic [15:0] ts, input bit bad);
        logic [7:0]  c;
        logic [15:0] d;
        logic        fb;
        pkt.delete();
        pkt.push_back(8'h54); pkt.push_back(8'h2C);
        pkt.push_back(spd[7:0]); pkt.push_back(spd[15:8]);
        pkt.push_back(s[7:0]); pkt.push_back(s[15:8]);
        for (int p = 0; p < np; p++) begin
            d = exp_dist(p);
            pkt.push_back(d[7:0]); pkt.push_back(d[15:8]); pkt.push_back(exp_int(p));
        end
        pkt.push_back(e[7:0]); pkt.push_back(e[15:8]);
        pkt.push_back(ts[7:0]); pkt.push_back(ts[15:8]);
        c = 8'h00;
        foreach (pkt[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ pkt[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h4D;
            end
        end
        if (bad) c = c ^ 8'h01;
        pkt.push_back(c);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1; bus.in_data = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pkt(input bit sel);
        foreach (pkt[i]) begin
            if (sel) begin bus2.in_valid = 1'b1; bus2.in_data = pkt[i]; end
            else     begin bus.in_valid  = 1'b1; bus.in_data  = pkt[i]; end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus2.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk(nm, bus.out_valid, 1);
    endtask

    task automatic quiet_check(input string nm, input int cycles);
        int highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) highs++;
        end
        chk(nm, highs, 0);
    endtask

    task automatic recv_main(input int s, input int e, input bit stall);
        int p = 0;
        int cyc = 0;
        bit xfer;
        while (p < 12 && cyc < 300) begin
            bus.out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    ang_seen[p] = int'(bus.out_angle);
                    chk("rec_angle", bus.out_angle, model_angle(s, e, 12, p));
                    chk("rec_dist", bus.out_dist, exp_dist(p));
                    chk("rec_intensity", bus.out_intensity, exp_int(p));
                    chk("rec_index", bus.out_index, p);
                    chk("rec_last", bus.out_last, (p == 11));
                end else begin
                    chk("stall_angle", bus.out_angle, model_angle(s, e, 12, p));
                    chk("stall_dist", bus.out_dist, exp_dist(p));
                    chk("stall_index", bus.out_index, p);
                end
            end
            xfer = bus.out_valid && bus.out_ready;
            @(posedge clk); #1;
            if (xfer) p++;
            cyc++;
        end
        chk("all_records", p, 12);
        chk("valid_drop_after_last", bus.out_valid, 0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          first, busy5;
        bit          emit;
        logic [15:0] prev_spd, prev_ts;

        vecs[0] = '{16'd3604,  16'd19647, 16'h1111, 16'hA001, 1'b0, 5062,  12354, 19647};
        vecs[1] = '{16'd35000, 16'd1000,  16'h2222, 16'hA002, 1'b0, 35181, 90,    1000};
        vecs[2] = '{16'd0,     16'd35999, 16'h3333, 16'hA003, 1'b0, 3272,  19635, 35999};
        vecs[3] = '{16'd100,   16'd200,   16'h4444, 16'hA004, 1'b1, 109,   154,   200};
        vecs[4] = '{16'd1000,  16'd1000,  16'h5555, 16'hA005, 1'b0, 1000,  1000,  1000};

        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = 8'h00; bus2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_crc_err", bus.crc_err, 0);
        chk("reset_overrun", bus.overrun, 0);
        chk("reset_speed", bus.speed, 0);
        chk("reset_timestamp", bus.timestamp, 0);
        chk("reset_angle", bus.out_angle, 0);
        rst = 1'b0;
        prev_spd = 16'h0000;
        prev_ts  = 16'h0000;

        for (int v = 0; v < 5; v++) begin
            emit = !(vecs[v].bad && CRC_EN);
            build_pkt(12, vecs[v].start_a, vecs[v].end_a, vecs[v].spd, vecs[v].ts, vecs[v].bad);
            send_pkt(1'b0);
            chk("crc_err_at_t1", bus.crc_err, vecs[v].bad && CRC_EN);
            first = -1;
            busy5 = 0;
            for (int k = 1; k <= 17; k++) begin
                @(posedge clk); #1;
                if (k == 1) chk("crc_err_one_cycle", bus.crc_err, 0);
                if (k == 5) busy5 = bus.busy;
                if (bus.out_valid && first < 0) first = k;
            end
            if (emit) begin
                chk("first_valid_latency", first, 17);
                chk("busy_in_divide", busy5, 1);
                recv_main(vecs[v].start_a, vecs[v].end_a, 1'b0);
                chk("tbl_angle_p1", ang_seen[1], vecs[v].a1);
                chk("tbl_angle_p6", ang_seen[6], vecs[v].a6);
                chk("tbl_angle_p11", ang_seen[11], vecs[v].a11);
                chk("busy_after_emit", bus.busy, 0);
                prev_spd = vecs[v].spd;
                prev_ts  = vecs[v].ts;
            end else begin
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1;
                    if (bus.out_valid && first < 0) first = k + 18;
                end
                chk("bad_crc_no_emit", first, -1);
            end
            chk("speed_latched", bus.speed, prev_spd);
            chk("timestamp_latched", bus.timestamp, prev_ts);
        end

        // Repeated header before VERLEN still frames the packet.
        send_byte(8'h54);
        build_pkt(12, 16'd500, 16'd2700, 16'h6666, 16'hB001, 1'b0);
        send_pkt(1'b0);
        wait_valid("resync_double_header");
        recv_main(500, 2700, 1'b0);

        // Aborted header, then a good packet: exactly one packet comes out.
        send_byte(8'h54);
        send_byte(8'h00);
        build_pkt(12, 16'd7000, 16'd9000, 16'h7777, 16'hB002, 1'b0);
        send_pkt(1'b0);
        wait_valid("resync_abort");
        recv_main(7000, 9000, 1'b0);
        quiet_check("resync_single_packet", 30);

        // Backpressure with 1-of-3 ready pattern.
        build_pkt(12, 16'd3604, 16'd19647, 16'h8888, 16'hB003, 1'b0);
        send_pkt(1'b0);
        wait_valid("stall_pkt_valid");
        recv_main(3604, 19647, 1'b1);

        // Byte injected while a record is stalled.
        build_pkt(12, 16'd20000, 16'd31000, 16'h9999, 16'hB004, 1'b0);
        send_pkt(1'b0);
        bus.out_ready = 1'b0;
        wait_valid("overrun_pkt_valid");
        bus.in_valid = 1'b1; bus.in_data = 8'h54;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("overrun_pulse", bus.overrun, 1);
        chk("overrun_keep_valid", bus.out_valid, 1);
        chk("overrun_keep_index", bus.out_index, 0);
        chk("overrun_keep_angle", bus.out_angle, 20000);
        @(posedge clk); #1;
        chk("overrun_single_pulse", bus.overrun, 0);
        recv_main(20000, 31000, 1'b0);

        // Reset while emitting index 5.
        build_pkt(12, 16'd1234, 16'd5678, 16'hAAAA, 16'hB005, 1'b0);
        send_pkt(1'b0);
        wait_valid("reset_pkt_valid");
        begin
            int n = 0;
            while (bus.out_index != 5 && n < 20) begin @(posedge clk); #1; n++; end
        end
        chk("reached_index5", bus.out_index, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_mid_emit_valid", bus.out_valid, 0);
        chk("reset_mid_emit_busy", bus.busy, 0);
        chk("reset_mid_emit_speed", bus.speed, 0);
        quiet_check("reset_mid_emit_quiet", 30);
        build_pkt(12, 16'd35000, 16'd1000, 16'hBBBB, 16'hB006, 1'b0);
        send_pkt(1'b0);
        wait_valid("post_reset_valid");
        recv_main(35000, 1000, 1'b0);

        // Two-point packet: angles are exactly start and end, across the wrap.
        build_pkt(2, 16'd35900, 16'd100, 16'hCCCC, 16'hB007, 1'b0);
        send_pkt(1'b1);
        begin
            int n = 0;
            while (!bus2.out_valid && n < 40) begin @(posedge clk); #1; n++; end
        end
        chk("p2_valid", bus2.out_valid, 1);
        chk("p2_angle0", bus2.out_angle, 35900);
        chk("p2_index0", bus2.out_index, 0);
        chk("p2_last0", bus2.out_last, 0);
        chk("p2_dist0", bus2.out_dist, exp_dist(0));
        @(posedge clk); #1;
        chk("p2_angle1", bus2.out_angle, 100);
        chk("p2_index1", bus2.out_index, 1);
        chk("p2_last1", bus2.out_last, 1);
        chk("p2_int1", bus2.out_intensity, exp_int(1));
        @(posedge clk); #1;
        chk("p2_valid_drop", bus2.out_valid, 0);
        chk("p2_speed", bus2.speed, 16'hCCCC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
